// File: rtl/int_sequencer_if.sv
// Stack-push handshake between the interrupt sequencer and the memory stage.
interface int_sequencer_if;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_data;

    modport master (output push_valid, output push_data, input push_ready);
    modport slave  (input push_valid, input push_data, output push_ready);
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry controller: drains the pipeline, pushes the return PC (and CCR
// when INT_CCR_SAVE_EN is defined) to the stack, then redirects fetch to the vector.
//
// state    | meaning
// IDLE     | waiting for a pending, unmasked request
// DRAIN    | fetch held while in-flight instructions reach MEM
// PUSH_PCH | pushing saved_pc[31:16]
// PUSH_PCL | pushing saved_pc[15:0]
// PUSH_CCR | pushing {13'b0, saved_ccr} (INT_CCR_SAVE_EN only)
// LOAD_VEC | one-cycle PC load of the interrupt vector
module int_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req,
    input  logic        int_mask,
    input  logic [31:0] pc_in,
    input  logic [2:0]  ccr_in,
    int_sequencer_if.master push,
    output logic        fetch_stall,
    output logic        flush_ifid,
    output logic        pc_load,
    output logic [31:0] pc_vector,
    output logic        int_busy,
    output logic        int_ack
);

    localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_PCL = 3'd3,
`ifdef INT_CCR_SAVE_EN
        PUSH_CCR = 3'd4,
`endif
        LOAD_VEC = 3'd5
    } state_t;

    state_t        state, state_n;
    logic          req_d;
    logic          pending;
    logic [CW-1:0] count;
    logic [31:0]   saved_pc;
    logic          flush_q;
    logic          start;
    logic          req_edge;
    logic          push_valid_c;
    logic [15:0]   push_data_c;
    logic          load_c;

`ifdef INT_CCR_SAVE_EN
    logic [2:0]    saved_ccr;
`else
    logic          unused_ccr;
    assign unused_ccr = ^ccr_in;
`endif

    assign req_edge = int_req & ~req_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        start        = 1'b0;
        push_valid_c = 1'b0;
        push_data_c  = 16'h0000;
        load_c       = 1'b0;
        case (state)
            IDLE: begin
                if (pending && !int_mask) begin
                    start   = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (count == '0) state_n = PUSH_PCH;
            end
            PUSH_PCH: begin
                push_valid_c = 1'b1;
                push_data_c  = saved_pc[31:16];
                if (push.push_ready) state_n = PUSH_PCL;
            end
            PUSH_PCL: begin
                push_valid_c = 1'b1;
                push_data_c  = saved_pc[15:0];
`ifdef INT_CCR_SAVE_EN
                if (push.push_ready) state_n = PUSH_CCR;
`else
                if (push.push_ready) state_n = LOAD_VEC;
`endif
            end
`ifdef INT_CCR_SAVE_EN
            PUSH_CCR: begin
                push_valid_c = 1'b1;
                push_data_c  = {13'b0, saved_ccr};
                if (push.push_ready) state_n = LOAD_VEC;
            end
`endif
            LOAD_VEC: begin
                load_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A fresh edge wins over the clear so a request arriving at capture is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d    <= 1'b0;
            pending  <= 1'b0;
            count    <= '0;
            saved_pc <= 32'h0;
            flush_q  <= 1'b0;
        end else begin
            req_d   <= int_req;
            flush_q <= start;
            if (req_edge)   pending <= 1'b1;
            else if (start) pending <= 1'b0;
            if (start) begin
                saved_pc <= pc_in;
                count    <= CNT_INIT;
            end else if (state == DRAIN && count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef INT_CCR_SAVE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        saved_ccr <= 3'b000;
        else if (start) saved_ccr <= ccr_in;
    end
`endif

    assign push.push_valid = push_valid_c;
    assign push.push_data  = push_data_c;
    assign fetch_stall     = (state != IDLE);
    assign int_busy        = (state != IDLE);
    assign flush_ifid      = flush_q;
    assign pc_load         = load_c;
    assign int_ack         = load_c;
    assign pc_vector       = VECTOR_ADDR;

endmodule
